// File: rtl/led_scan_decoder_pkg.sv
// led_scan_decoder_pkg: shared glyph table, FSM states and anode helpers for the LED scan decoder.
package led_scan_decoder_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT_OFF} state_t;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN3_ON = 4'b0111;
    localparam logic [3:0] AN2_ON = 4'b1011;
    localparam logic [3:0] AN1_ON = 4'b1101;
    localparam logic [3:0] AN0_ON = 4'b1110;

    // Active-low {a,b,c,d,e,f,g} glyphs, indexed by hex value.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic one_hot_low(input logic [3:0] a);
        return a inside {AN3_ON, AN2_ON, AN1_ON, AN0_ON};
    endfunction

    function automatic logic multi_low(input logic [3:0] a);
        return $countones(~a) > 1;
    endfunction

    function automatic logic [1:0] slot_of(input logic [3:0] a);
        return a == AN3_ON ? 2'd3 : a == AN2_ON ? 2'd2 : a == AN1_ON ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/led_scan_decoder_seg7_to_hex.sv
// seg7_to_hex: combinational decode of an active-low 7-segment pattern into a hex value and legal flag.
module seg7_to_hex
    import led_scan_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       legal
);

    always_comb begin
        value = 4'h0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++)
            if (pattern == GLYPH[i]) begin
                value = 4'(i);
                legal = 1'b1;
            end
    end

endmodule

// File: rtl/led_scan_decoder.sv
// led_scan_decoder: rebuilds four hex digits from a multiplexed LED bus, one atomic word per scan frame.
// Define LED_SCAN_DP_EN to also capture the active-low decimal point into dps.
module led_scan_decoder
    import led_scan_decoder_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
`ifdef LED_SCAN_DP_EN
    input  logic        dp,
    output logic [3:0]  dps,
`endif
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic        order_err
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [3:0]    an_q, pat, pat_n;
    logic [6:0]    seg_q, c_seg;
    logic [CW-1:0] cnt, cnt_n;
    state_t        state, state_n;
    logic          multi, multi_q, load, cap, c_v;
    logic [1:0]    c_slot, idx, sidx;
    logic [11:0]   shadow;
    logic [3:0]    val;
    logic          legal;
`ifdef LED_SCAN_DP_EN
    logic          dp_q, c_dp;
    logic [2:0]    shadow_dp;
`endif

    assign multi = multi_low(an_q);
    assign sidx  = c_slot - 2'd1;

    seg7_to_hex u_dec (
        .pattern(c_seg),
        .value  (val),
        .legal  (legal)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        load    = 1'b0;
        cap     = 1'b0;
        if (multi) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: load = one_hot_low(an_q);
                S_SETTLE, S_WAIT_OFF:
                    if (an_q == pat) begin
                        if (state == S_SETTLE) begin
                            cnt_n = cnt == CW'(SETTLE) ? cnt : cnt + 1'b1;
                            cap   = cnt_n == CW'(SETTLE);
                        end
                    end else if (one_hot_low(an_q)) begin
                        load = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                default: state_n = S_IDLE;
            endcase
        end
        if (load) begin
            state_n = S_SETTLE;
            cnt_n   = CW'(1);
            pat_n   = an_q;
            cap     = SETTLE == 1;
        end
        if (cap)
            state_n = S_WAIT_OFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q    <= AN_OFF;
            seg_q   <= 7'h7F;
            state   <= S_IDLE;
            cnt     <= '0;
            pat     <= AN_OFF;
            multi_q <= 1'b0;
            c_v     <= 1'b0;
            c_seg   <= 7'h7F;
            c_slot  <= 2'd0;
`ifdef LED_SCAN_DP_EN
            dp_q    <= 1'b1;
            c_dp    <= 1'b1;
`endif
        end else begin
            an_q    <= an;
            seg_q   <= seg;
            state   <= state_n;
            cnt     <= cnt_n;
            pat     <= pat_n;
            multi_q <= multi;
            c_v     <= cap;
            c_seg   <= cap ? seg_q : c_seg;
            c_slot  <= cap ? slot_of(an_q) : c_slot;
`ifdef LED_SCAN_DP_EN
            dp_q    <= dp;
            c_dp    <= cap ? dp_q : c_dp;
`endif
        end
    end

    // Frame assembly runs one edge behind the capture; an_err pre-empts any capture result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= 2'd0;
            shadow      <= '0;
            digits      <= 16'h0000;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            order_err   <= 1'b0;
`ifdef LED_SCAN_DP_EN
            shadow_dp   <= '0;
            dps         <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            order_err   <= 1'b0;
            an_err      <= multi && !multi_q;
            if (multi) begin
                idx <= 2'd0;
            end else if (c_v) begin
                if (!legal) begin
                    seg_err <= 1'b1;
                    idx     <= 2'd0;
                end else if (c_slot == 2'd3 || (c_slot == ~idx && c_slot != 2'd0)) begin
                    shadow[{sidx, 2'b00} +: 4] <= val;
                    idx <= c_slot == 2'd3 ? 2'd1 : idx + 2'd1;
`ifdef LED_SCAN_DP_EN
                    shadow_dp[sidx] <= c_dp;
`endif
                end else if (c_slot != ~idx) begin
                    order_err <= 1'b1;
                    idx       <= 2'd0;
                end else begin
                    digits      <= {shadow, val};
                    frame_valid <= 1'b1;
                    idx         <= 2'd0;
`ifdef LED_SCAN_DP_EN
                    dps         <= {shadow_dp, c_dp};
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scan_decoder.sv
// tb_led_scan_decoder: directed-vector bench for led_scan_decoder with SETTLE=2.
module tb_led_scan_decoder;
    import led_scan_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        frame_valid, seg_err, an_err, order_err;
`ifdef LED_SCAN_DP_EN
    logic        dp = 1'b1;
    logic [3:0]  dps;
`endif

    int vectors = 0, miscompares = 0;
    int n_fv = 0, n_seg = 0, n_an = 0, n_ord = 0, n_ovl = 0;

    led_scan_decoder #(.SETTLE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .seg        (seg),
`ifdef LED_SCAN_DP_EN
        .dp         (dp),
        .dps        (dps),
`endif
        .digits     (digits),
        .frame_valid(frame_valid),
        .seg_err    (seg_err),
        .an_err     (an_err),
        .order_err  (order_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) n_fv++;
        if (seg_err) n_seg++;
        if (an_err) n_an++;
        if (order_err) n_ord++;
        if ($countones({frame_valid, seg_err, an_err, order_err}) > 1) n_ovl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] d, input int n);
        show(AN3_ON, GLYPH[d[15:12]], n);
        show(AN2_ON, GLYPH[d[11:8]], n);
        show(AN1_ON, GLYPH[d[7:4]], n);
        show(AN0_ON, GLYPH[d[3:0]], n);
        show(AN_OFF, 7'h7F, 4);
    endtask

    initial begin
        reset = 1'b0;
        an    = AN_OFF;
        seg   = 7'h7F;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 16'h0000);
        check("rst_pulses", {frame_valid, seg_err, an_err, order_err}, 4'h0);
        reset = 1'b1;
        show(AN_OFF, 7'h7F, 10);
        check("idle_pulses", n_fv + n_seg + n_an + n_ord, 0);

        // Frame 1234 with exact frame_valid timing on the last digit
        show(AN3_ON, GLYPH[1], 4);
        show(AN2_ON, GLYPH[2], 4);
        show(AN1_ON, GLYPH[3], 4);
        show(AN0_ON, GLYPH[4], 3);
        check("fv_early", frame_valid, 1'b0);
        check("digits_early", digits, 16'h0000);
        @(negedge clk);
        check("fv_edge", frame_valid, 1'b1);
        check("digits_1234", digits, 16'h1234);
        @(negedge clk);
        check("fv_one_cycle", frame_valid, 1'b0);
        show(AN_OFF, 7'h7F, 4);
        check("n_fv_1", n_fv, 1);
        check("err_1", n_seg + n_an + n_ord, 0);

        // AN2 held one cycle: never captured, AN1 and then AN0 both arrive out of order
        show(AN3_ON, GLYPH[9], 4);
        show(AN2_ON, GLYPH[8], 1);
        show(AN1_ON, GLYPH[7], 4);
        show(AN0_ON, GLYPH[6], 4);
        show(AN_OFF, 7'h7F, 4);
        check("ord_cnt", n_ord, 2);
        check("ord_fv", n_fv, 1);
        check("ord_digits", digits, 16'h1234);

        // Two anodes low for three cycles gives a single an_err
        show(4'b1100, 7'h7F, 3);
        show(AN_OFF, 7'h7F, 3);
        check("an_cnt", n_an, 1);
        check("an_others", n_seg + n_ord, 2);
        scan(16'hABCD, 4);
        check("digits_abcd", digits, 16'hABCD);
        check("n_fv_2", n_fv, 2);

        // Blank AN1 pattern aborts the frame; AN0 then lands at index 0
        show(AN3_ON, GLYPH[14], 4);
        show(AN2_ON, GLYPH[15], 4);
        show(AN1_ON, 7'h7F, 4);
        show(AN0_ON, GLYPH[0], 4);
        show(AN_OFF, 7'h7F, 4);
        check("seg_cnt", n_seg, 1);
        check("seg_ord", n_ord, 3);
        check("seg_fv", n_fv, 2);
        check("seg_digits", digits, 16'hABCD);

        // Each digit held exactly SETTLE cycles is still captured
        scan(16'h0123, 2);
        check("digits_0123", digits, 16'h0123);
        check("n_fv_3", n_fv, 3);

        // Asynchronous reset in the middle of a frame
        show(AN3_ON, GLYPH[5], 4);
        show(AN2_ON, GLYPH[6], 4);
        show(AN1_ON, GLYPH[7], 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_digits", digits, 16'h0000);
        check("midrst_pulses", {frame_valid, seg_err, an_err, order_err}, 4'h0);
        show(AN1_ON, GLYPH[7], 3);
        check("inrst_digits", digits, 16'h0000);
        reset = 1'b1;
        show(AN_OFF, 7'h7F, 3);
        check("rst_no_pulses", n_fv + n_seg + n_an + n_ord, 3 + 1 + 1 + 3);
        scan(16'h5678, 4);
        check("digits_5678", digits, 16'h5678);
        check("n_fv_4", n_fv, 4);
        check("no_overlap", n_ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_scan_decoder.md
# led_scan_decoder

Receive-side counterpart of the four-digit LED driver. Samples the multiplexed display bus the driver produces (active-low anodes AN3..AN0 plus active-low segments). Reconstructs the four displayed hex digits and publishes them as one atomic 16-bit word per completed scan frame. Used in the loopback self-check build and as a bus checker in benches.

## Interface
- SETTLE, 2: consecutive cycles an anode pattern must be stable before its segments are captured (1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- an  in  4  {AN3,AN2,AN1,AN0}; active-low anode enables.
- seg  in  7  {a,b,c,d,e,f,g}; active-low segment lines.
- digits  out  16  {digit3,digit2,digit1,digit0}; last complete frame.
- frame_valid  out  1  one-cycle pulse; digits updated on the same edge.
- seg_err  out  1  one-cycle pulse; captured pattern is not a legal hex glyph.
- an_err  out  1  one-cycle pulse; more than one anode low.
- order_err  out  1  one-cycle pulse; digit arrived out of scan order.

## Operation
- Glyph table, active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. Any other pattern is illegal.
- States: IDLE (an==1111 or after error), SETTLE (one-hot-low pattern, counting), WAIT_OFF (captured, waiting for pattern change).
- IDLE -> SETTLE when `an` is one-hot-low. Counter loads 1.
- In SETTLE, the counter increments each cycle `an` is unchanged. On reaching SETTLE, capture: decode `seg` into the shadow slot for that anode, then go to WAIT_OFF.
- SETTLE, any change of `an`: restart counting for the new pattern if it is one-hot-low, otherwise go to IDLE. No capture.
- WAIT_OFF -> IDLE on 1111. WAIT_OFF -> SETTLE (count=1) on a different one-hot-low pattern.
- Multiple anodes low, any state: an_err pulse, go to IDLE, scan index cleared.
- Scan order is fixed: AN3, AN2, AN1, AN0, and the index advances on each capture.
  - Capture of AN3 always (re)starts a frame at index 1.
  - Capture of any other anode not matching the index: order_err, index cleared, shadow discarded.
- Illegal glyph on capture: seg_err pulse, index cleared, frame aborted.
- Capture of AN0 at index 3 with legal glyph: shadow plus new digit copied to `digits`, frame_valid pulsed, index cleared.
- All error pulses are mutually exclusive per cycle; an_err has priority.

## Timing
- Reset: state IDLE, counter 0, index 0, shadow 0, digits=16'h0000, frame_valid/seg_err/an_err/order_err=0.
- `an`/`seg` are registered once on input (1-cycle sampling latency); all timing below is measured at the registered copy.
- Capture edge = SETTLE-th consecutive cycle of a stable one-hot-low pattern. frame_valid asserts on the edge after the AN0 capture.
- Pulses last exactly one cycle; never asserted in reset.
- Counter width $clog2(SETTLE+1), saturates and never wraps.
- Reset asserted mid-frame: immediate clear, partial frame lost, no pulses.

## Configuration
- LED_SCAN_DP_EN defined: extra input `dp` (1 bit, active-low) and output `dps` (4 bits). Each capture also samples `dp`, and `dps` updates atomically with `digits`. `dp` never affects glyph legality.
- LED_SCAN_DP_EN undefined: no `dp`/`dps` ports and no decimal-point logic.

## Structure
- Shared package/header: glyph constants, state encodings, anode one-hot constants.
- Sub-module seg7_to_hex: combinational, 7-bit pattern in, 4-bit value plus legal flag out.

## Test plan
- Reset low with bus idle: all outputs 0. Release, drive 1111 for 10 cycles: no pulses.
- Scan 1,2,3,4 (AN3..AN0, 4 cycles each, SETTLE=2): one frame_valid, digits=16'h1234.
- Scan with AN2 held 1 cycle only: no capture for AN2; AN1 capture raises order_err; digits unchanged.
- an=1100 for 3 cycles: an_err pulse. Next clean scan A,b,C,d: digits=16'hABCD.
- AN1 segment pattern 1111111: seg_err pulse, no frame_valid. Next clean frame is accepted.
- Reset asserted during AN1 of scan 5,6,7,8: outputs cleared. Subsequent full scan 5,6,7,8: digits=16'h5678.
